// File: rtl/qdiv_seq.sv
// ============================================================================
// Module   : qdiv_seq
// Brief    : Sequential sign-magnitude Q-format divider (restoring, 1 bit/clk)
// Revision : 1.0
// ============================================================================
`default_nettype none

module qdiv_seq #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic         o_busy,
    output logic         o_complete,
    output logic         o_ovr
);

    localparam int W  = N - 1 + Q;
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [W-1:0]  r_dq;
    logic [N-2:0]  r_div;
    logic [N-1:0]  r_rem;
    logic          r_sign;
    logic [N-1:0]  r_quo;
    logic          r_ovr;

    logic [N-1:0]  w_trial;
    logic          w_ge;
    logic [N-1:0]  w_rem_next;
    logic [W-1:0]  w_dq_next;
    logic          w_last;
    logic          w_ovr;
    logic [N-2:0]  w_mag;
    logic          w_sign;

    always_comb begin
        w_trial    = {r_rem[N-2:0], r_dq[W-1]};
        w_ge       = (w_trial >= {1'b0, r_div});
        w_rem_next = w_ge ? (w_trial - {1'b0, r_div}) : w_trial;
        w_dq_next  = {r_dq[W-2:0], w_ge};
        w_last     = (r_cnt == CW'(W - 1));
        w_ovr      = (|w_dq_next[W-1:N-1]) | (r_div == '0);
        w_mag      = w_ovr ? {(N-1){1'b1}} : w_dq_next[N-2:0];
        // No negative zero: the sign only survives on a nonzero magnitude.
        w_sign     = r_sign & (w_mag != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dq    <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_sign  <= 1'b0;
            r_quo   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dq    <= {i_dividend[N-2:0], {Q{1'b0}}};
                        r_div   <= i_divisor[N-2:0];
                        r_sign  <= i_dividend[N-1] ^ i_divisor[N-1];
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_dq  <= w_dq_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quo   <= {w_sign, w_mag};
                        r_ovr   <= w_ovr;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_quotient = r_quo;
    assign o_ovr      = r_ovr;
    assign o_busy     = (r_state == S_RUN) || (r_state == S_DONE);
    assign o_complete = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_qdiv_seq.sv
// ============================================================================
// Module   : tb_qdiv_seq
// Brief    : Directed self-checking bench for qdiv_seq (N=16, Q=8)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_qdiv_seq;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_dividend;
    logic [15:0] i_divisor;
    logic [15:0] o_quotient;
    logic        o_busy;
    logic        o_complete;
    logic        o_ovr;

    int n_pass;
    int n_total;

    qdiv_seq #(.Q(8), .N(16)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_quotient (o_quotient),
        .o_busy     (o_busy),
        .o_complete (o_complete),
        .o_ovr      (o_ovr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Launch one division from IDLE and measure edges from acceptance to o_complete.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic ovr,
                          output int lat, output logic pulse2);
        @(negedge i_clk);
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        lat = -1;
        q   = 'x;
        ovr = 1'bx;
        for (int c = 1; c <= 60; c++) begin
            @(posedge i_clk);
            #1;
            if (o_complete) begin
                lat = c;
                q   = o_quotient;
                ovr = o_ovr;
                break;
            end
        end
        @(posedge i_clk);
        #1 pulse2 = o_complete;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
        #2;
        n_total++; if (o_quotient !== 16'h0000) $display("FAIL reset_quotient: got %h expected 0000", o_quotient); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else n_pass++;
        n_total++; if (o_complete !== 1'b0) $display("FAIL reset_complete: got %b expected 0", o_complete); else n_pass++;
        n_total++; if (o_ovr !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", o_ovr); else n_pass++;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] q; logic ovr; int lat; logic p2;
        do_div(16'h0180, 16'h0080, q, ovr, lat, p2);
        n_total++; if (q !== 16'h0300) $display("FAIL basic_quotient: got %h expected 0300", q); else n_pass++;
        n_total++; if (ovr !== 1'b0) $display("FAIL basic_ovr: got %b expected 0", ovr); else n_pass++;
        n_total++; if (lat !== 23) $display("FAIL basic_latency: got %0d expected 23", lat); else n_pass++;
        n_total++; if (p2 !== 1'b0) $display("FAIL basic_pulse_width: got %b expected 0", p2); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL basic_idle_busy: got %b expected 0", o_busy); else n_pass++;
        n_total++; if (o_quotient !== 16'h0300) $display("FAIL basic_hold: got %h expected 0300", o_quotient); else n_pass++;
    endtask

    task automatic test_signs();
        logic [15:0] a [3]; logic [15:0] b [3]; logic [15:0] e [3];
        logic [15:0] q; logic ovr; int lat; logic p2;
        a = '{16'h8180, 16'h8180, 16'h8000};
        b = '{16'h0080, 16'h8080, 16'h0080};
        e = '{16'h8300, 16'h0300, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            do_div(a[i], b[i], q, ovr, lat, p2);
            n_total++; if (q !== e[i]) $display("FAIL sign_quotient[%0d]: got %h expected %h", i, q, e[i]); else n_pass++;
            n_total++; if (ovr !== 1'b0) $display("FAIL sign_ovr[%0d]: got %b expected 0", i, ovr); else n_pass++;
        end
    endtask

    task automatic test_trunc();
        logic [15:0] q; logic ovr; int lat; logic p2;
        do_div(16'h0100, 16'h0300, q, ovr, lat, p2);
        n_total++; if (q !== 16'h0055) $display("FAIL trunc_quotient: got %h expected 0055", q); else n_pass++;
        n_total++; if (ovr !== 1'b0) $display("FAIL trunc_ovr: got %b expected 0", ovr); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] q; logic ovr; int lat; logic p2;
        do_div(16'h7F00, 16'h0001, q, ovr, lat, p2);
        n_total++; if (q !== 16'h7FFF) $display("FAIL ovf_quotient: got %h expected 7fff", q); else n_pass++;
        n_total++; if (ovr !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", ovr); else n_pass++;
        n_total++; if (lat !== 23) $display("FAIL ovf_latency: got %0d expected 23", lat); else n_pass++;
        do_div(16'h8100, 16'h0000, q, ovr, lat, p2);
        n_total++; if (q !== 16'hFFFF) $display("FAIL dz_quotient: got %h expected ffff", q); else n_pass++;
        n_total++; if (ovr !== 1'b1) $display("FAIL dz_flag: got %b expected 1", ovr); else n_pass++;
        n_total++; if (lat !== 23) $display("FAIL dz_latency: got %0d expected 23", lat); else n_pass++;
    endtask

    task automatic test_midrun_start();
        logic [15:0] prev; int c; int lat;
        @(negedge i_clk);
        i_dividend = 16'h0180; i_divisor = 16'h0080; i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        prev = o_quotient;
        c = 0;
        repeat (5) begin @(posedge i_clk); c++; end
        @(negedge i_clk);
        i_dividend = 16'h7F00; i_divisor = 16'h0001; i_start = 1'b1;
        @(posedge i_clk); c++;
        #1 i_start = 1'b0;
        n_total++; if (o_quotient !== prev) $display("FAIL midrun_hold: got %h expected %h", o_quotient, prev); else n_pass++;
        lat = -1;
        while (c < 60) begin
            @(posedge i_clk); c++;
            #1;
            if (o_complete) begin lat = c; break; end
        end
        n_total++; if (lat !== 23) $display("FAIL midrun_latency: got %0d expected 23", lat); else n_pass++;
        n_total++; if (o_quotient !== 16'h0300) $display("FAIL midrun_quotient: got %h expected 0300", o_quotient); else n_pass++;
        n_total++; if (o_ovr !== 1'b0) $display("FAIL midrun_ovr: got %b expected 0", o_ovr); else n_pass++;
        @(posedge i_clk);
    endtask

    task automatic test_start_held();
        int c; int lat1; int lat2; logic [15:0] q1; logic busy_idle; logic busy_acc;
        @(negedge i_clk);
        i_dividend = 16'h0180; i_divisor = 16'h0080; i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_dividend = 16'h0100; i_divisor = 16'h0300;
        c = 0; lat1 = -1; q1 = 'x;
        while (c < 60) begin
            @(posedge i_clk); c++;
            #1;
            if (o_complete) begin lat1 = c; q1 = o_quotient; break; end
        end
        @(posedge i_clk); c++;
        #1 busy_idle = o_busy;
        @(posedge i_clk); c++;
        #1 busy_acc = o_busy;
        i_start = 1'b0;
        lat2 = -1;
        while (c < 120) begin
            @(posedge i_clk); c++;
            #1;
            if (o_complete) begin lat2 = c; break; end
        end
        n_total++; if (lat1 !== 23) $display("FAIL held_latency1: got %0d expected 23", lat1); else n_pass++;
        n_total++; if (q1 !== 16'h0300) $display("FAIL held_quotient1: got %h expected 0300", q1); else n_pass++;
        n_total++; if (busy_idle !== 1'b0) $display("FAIL held_idle_gap: got %b expected 0", busy_idle); else n_pass++;
        n_total++; if (busy_acc !== 1'b1) $display("FAIL held_reaccept: got %b expected 1", busy_acc); else n_pass++;
        n_total++; if (lat2 !== 48) $display("FAIL held_latency2: got %0d expected 48", lat2); else n_pass++;
        n_total++; if (o_quotient !== 16'h0055) $display("FAIL held_quotient2: got %h expected 0055", o_quotient); else n_pass++;
        @(posedge i_clk);
    endtask

    task automatic test_reset_mid();
        logic busy_before; logic seen; logic [15:0] q; logic ovr; int lat; logic p2;
        @(negedge i_clk);
        i_dividend = 16'h0180; i_divisor = 16'h0080; i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        busy_before = o_busy;
        #1 i_rst = 1'b1;
        #1;
        n_total++; if (busy_before !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy_before); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", o_busy); else n_pass++;
        n_total++; if (o_quotient !== 16'h0000) $display("FAIL rstmid_quotient: got %h expected 0000", o_quotient); else n_pass++;
        n_total++; if (o_ovr !== 1'b0) $display("FAIL rstmid_ovr: got %b expected 0", o_ovr); else n_pass++;
        n_total++; if (o_complete !== 1'b0) $display("FAIL rstmid_complete: got %b expected 0", o_complete); else n_pass++;
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge i_clk);
            #1 if (o_complete) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL rstmid_no_complete: got %b expected 0", seen); else n_pass++;
        do_div(16'h0200, 16'h0100, q, ovr, lat, p2);
        n_total++; if (q !== 16'h0200) $display("FAIL rstmid_after_quotient: got %h expected 0200", q); else n_pass++;
        n_total++; if (lat !== 23) $display("FAIL rstmid_after_latency: got %0d expected 23", lat); else n_pass++;
        n_total++; if (ovr !== 1'b0) $display("FAIL rstmid_after_ovr: got %b expected 0", ovr); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_signs();
        test_trunc();
        test_midrun_start();
        test_start_held();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
